systolic_feeder: RTL and testbench

- Transmit side of the systolic MAC array input interface.
- Accepts one K-step per handshake: a column slice of A (one 16-bit element per array row) and a row slice of B (one 16-bit element per array column).
- Applies the diagonal skew (lane i delayed i cycles relative to lane 0) and drives the array's horizontal and vertical input buses.
- Sequences a tile: FEED for cfg_k beats, then zero-flush, then signals completion to the controller.

---
 rtl/systolic_feeder_pkg.sv | 20 ++
 rtl/systolic_feeder_if.sv | 35 +++
 rtl/systolic_feeder_skew_delay_line.sv | 26 ++
 rtl/systolic_feeder.sv | 130 +++++++++++++
 tb/tb_systolic_feeder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feeder_pkg.sv
// rtl/systolic_feeder_pkg.sv - shared types, defaults and lane helpers for the systolic feeder
package systolic_feeder_pkg;

  localparam int ARR_SIZE_DEF      = 4;
  localparam int HORIZONTAL_BW_DEF = 16;
  localparam int K_W_DEF           = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Low bit of lane i inside a packed bus: lane i is [(i+1)*bw-1 : i*bw]
  function automatic int lane_lo(input int i, input int bw);
    return i * bw;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - controller/stream/array bus bundle of the systolic feeder
interface systolic_feeder_if
  import systolic_feeder_pkg::*;
#(
  parameter int ARR_SIZE      = ARR_SIZE_DEF,
  parameter int HORIZONTAL_BW = HORIZONTAL_BW_DEF,
  parameter int K_W           = K_W_DEF
) ();

  localparam int BUS_W = ARR_SIZE * HORIZONTAL_BW;

  logic             i_mode;
  logic             start;
  logic [K_W-1:0]   cfg_k;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_a;
  logic [BUS_W-1:0] in_b;
  logic [BUS_W-1:0] horizontal_input;
  logic [BUS_W-1:0] vertical_input;
  logic             o_mode;
  logic             busy;
  logic             tile_done;

  modport master (
    output i_mode, start, cfg_k, in_valid, in_a, in_b,
    input  in_ready, horizontal_input, vertical_input, o_mode, busy, tile_done
  );

  modport slave (
    input  i_mode, start, cfg_k, in_valid, in_a, in_b,
    output in_ready, horizontal_input, vertical_input, o_mode, busy, tile_done
  );

endinterface

// File: rtl/systolic_feeder_skew_delay_line.sv
// rtl/systolic_feeder_skew_delay_line.sv - fixed-depth shift chain giving one lane its skew
module systolic_feeder_skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] chain_q [DEPTH];

  // Shift every cycle; stage 0 captures the entering beat, last stage drives the array edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) chain_q[k] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) chain_q[k] <= chain_q[k-1];
    end
  end

  assign q_o = chain_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - tile sequencer and diagonal skew for the systolic array input buses
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int ARR_SIZE      = ARR_SIZE_DEF,
  parameter int HORIZONTAL_BW = HORIZONTAL_BW_DEF,
  parameter int K_W           = K_W_DEF,
  parameter int FLUSH_CYCLES  = 2 * ARR_SIZE
) (
  input  logic clk,
  input  logic rst,
  systolic_feeder_if.slave bus
);

  localparam int BUS_W = ARR_SIZE * HORIZONTAL_BW;
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_FEED  = 2'(ST_FEED);
  localparam logic [1:0] S_FLUSH = 2'(ST_FLUSH);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);

  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [K_W-1:0]   cfg_k_q, cfg_k_d;
  logic [K_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             mode_q, mode_d;

  logic             accept;
  logic [K_W-1:0]   beat_nxt;
  logic [BUS_W-1:0] feed_a, feed_b;
  wire  [BUS_W-1:0] h_bus;
  wire  [BUS_W-1:0] v_bus;

  assign accept   = (state_q == S_FEED) && bus.in_valid;
  assign beat_nxt = beat_cnt_q + K_W'(1);

  // Anything not accepted (bubble, flush, idle) enters the skew lines as zeros
  assign feed_a = accept ? bus.in_a : '0;
  assign feed_b = accept ? bus.in_b : '0;

  // Tile sequencing: configuration is captured only when a start is taken in IDLE
  always_comb begin
    state_d     = state_q;
    cfg_k_d     = cfg_k_q;
    mode_d      = mode_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cfg_k_d     = bus.cfg_k;
          mode_d      = bus.i_mode;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = (bus.cfg_k != '0) ? S_FEED : S_FLUSH;
        end
      end
      S_FEED: begin
        if (accept) begin
          beat_cnt_d = beat_nxt;
          if (beat_nxt == cfg_k_q) begin
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = S_DONE;
        else flush_cnt_d = flush_cnt_q + FC_W'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers; reset aborts any tile in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_k_q     <= '0;
      mode_q      <= 1'b0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_k_q     <= cfg_k_d;
      mode_q      <= mode_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Lane i on both buses is delayed i+1 cycles, forming the diagonal wavefront
  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    systolic_feeder_skew_delay_line #(
      .DEPTH (i + 1),
      .WIDTH (HORIZONTAL_BW)
    ) u_skew_h (
      .clk (clk),
      .rst (rst),
      .d_i (feed_a[lane_lo(i, HORIZONTAL_BW) +: HORIZONTAL_BW]),
      .q_o (h_bus[lane_lo(i, HORIZONTAL_BW) +: HORIZONTAL_BW])
    );

    systolic_feeder_skew_delay_line #(
      .DEPTH (i + 1),
      .WIDTH (HORIZONTAL_BW)
    ) u_skew_v (
      .clk (clk),
      .rst (rst),
      .d_i (feed_b[lane_lo(i, HORIZONTAL_BW) +: HORIZONTAL_BW]),
      .q_o (v_bus[lane_lo(i, HORIZONTAL_BW) +: HORIZONTAL_BW])
    );
  end

  assign bus.horizontal_input = h_bus;
  assign bus.vertical_input   = v_bus;
  assign bus.in_ready         = (state_q == S_FEED);
  assign bus.busy             = (state_q == S_FEED) || (state_q == S_FLUSH);
  assign bus.tile_done        = (state_q == S_DONE);
  assign bus.o_mode           = mode_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder
module tb_systolic_feeder;

  localparam int ARR   = 4;
  localparam int BW    = 16;
  localparam int KW    = 16;
  localparam int FLUSH = 8;
  localparam int W     = ARR * BW;

  typedef struct {
    logic          start;
    logic [KW-1:0] cfg_k;
    logic          mode;
    logic          valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          rdy;
    logic          busy;
    logic          done;
    logic          omode;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_feeder_if #(.ARR_SIZE(ARR), .HORIZONTAL_BW(BW), .K_W(KW)) bus ();

  systolic_feeder #(
    .ARR_SIZE(ARR), .HORIZONTAL_BW(BW), .K_W(KW), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  logic [W-1:0] ent_a_q[$];
  logic [W-1:0] ent_b_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_beat();
    logic [W-1:0] r;
    for (int i = 0; i < ARR; i++) r[i*BW +: BW] = 16'($urandom) | 16'd1;
    return r;
  endfunction

  // Scoreboard holds ARR zeros standing for the cleared skew lines
  task automatic sb_init();
    ent_a_q.delete();
    ent_b_q.delete();
    repeat (ARR) begin
      ent_a_q.push_back('0);
      ent_b_q.push_back('0);
    end
  endtask

  // Lane i now must show the beat that entered i+1 cycles ago
  task automatic check_lanes();
    int n;
    logic [W-1:0] ea, eb;
    n = ent_a_q.size();
    for (int i = 0; i < ARR; i++) begin
      ea = ent_a_q[n-2-i];
      eb = ent_b_q[n-2-i];
      chk($sformatf("h_lane%0d", i), W'(bus.horizontal_input[i*BW +: BW]), W'(ea[i*BW +: BW]));
      chk($sformatf("v_lane%0d", i), W'(bus.vertical_input[i*BW +: BW]), W'(eb[i*BW +: BW]));
    end
    while (ent_a_q.size() > ARR) begin
      void'(ent_a_q.pop_front());
      void'(ent_b_q.pop_front());
    end
  endtask

  task automatic apply(input vec_t v);
    bus.start    = v.start;
    bus.cfg_k    = v.cfg_k;
    bus.i_mode   = v.mode;
    bus.in_valid = v.valid;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    if (v.rdy && v.valid) begin
      ent_a_q.push_back(v.a);
      ent_b_q.push_back(v.b);
    end else begin
      ent_a_q.push_back('0);
      ent_b_q.push_back('0);
    end
    @(negedge clk);
    chk("in_ready", W'(bus.in_ready), W'(v.rdy));
    chk("busy", W'(bus.busy), W'(v.busy));
    chk("tile_done", W'(bus.tile_done), W'(v.done));
    chk("o_mode", W'(bus.o_mode), W'(v.omode));
    check_lanes();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input int k, input logic md, input logic vl,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic rdy, input logic bsy, input logic dn, input logic om);
    vec_t v;
    v.start = st; v.cfg_k = KW'(k); v.mode = md; v.valid = vl;
    v.a = a; v.b = b; v.rdy = rdy; v.busy = bsy; v.done = dn; v.omode = om;
    vecs.push_back(v);
  endtask

  // Flush rows present valid data that must not be taken
  task automatic add_tail(input logic om, input int idle_rows);
    repeat (FLUSH) add(1'b0, 0, ~om, 1'b1, rnd_beat(), rnd_beat(), 1'b0, 1'b1, 1'b0, om);
    add(1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, om);
    repeat (idle_rows) add(1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, om);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  logic [W-1:0] skew_a, skew_b;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_k = '0; bus.i_mode = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    sb_init();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_h", bus.horizontal_input, '0);
    chk("rst_v", bus.vertical_input, '0);
    chk("rst_ready", W'(bus.in_ready), '0);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.tile_done), '0);
    chk("rst_mode", W'(bus.o_mode), '0);
    rst = 1'b0;

    // Skew: single beat walks down the diagonal
    skew_a = {16'd4, 16'd3, 16'd2, 16'd1};
    skew_b = {16'd8, 16'd7, 16'd6, 16'd5};
    add(1'b1, 1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b1, skew_a, skew_b, 1'b1, 1'b1, 1'b0, 1'b0);
    add_tail(1'b0, ARR + 1);
    run_vecs();

    // Back-to-back cfg_k=3, valid held high throughout
    add(1'b1, 3, 1'b1, 1'b1, rnd_beat(), rnd_beat(), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) add(1'b0, 0, 1'b1, 1'b1, rnd_beat(), rnd_beat(), 1'b1, 1'b1, 1'b0, 1'b1);
    add_tail(1'b1, 2);
    run_vecs();

    // Bubbles between two beats
    add(1'b1, 2, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 0, 1'b0, 1'b1, rnd_beat(), rnd_beat(), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) add(1'b0, 0, 1'b0, 1'b0, rnd_beat(), rnd_beat(), 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b1, rnd_beat(), rnd_beat(), 1'b1, 1'b1, 1'b0, 1'b0);
    add_tail(1'b0, ARR);
    run_vecs();

    // cfg_k=0 goes straight to flush
    add(1'b1, 0, 1'b1, 1'b1, rnd_beat(), rnd_beat(), 1'b0, 1'b0, 1'b0, 1'b0);
    add_tail(1'b1, 1);
    run_vecs();

    // start/cfg_k/i_mode changes mid-tile are ignored
    add(1'b1, 2, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 5, 1'b1, 1'b1, rnd_beat(), rnd_beat(), 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 5, 1'b1, 1'b1, rnd_beat(), rnd_beat(), 1'b1, 1'b1, 1'b0, 1'b0);
    add_tail(1'b0, ARR);
    run_vecs();

    // Reset in the middle of a cfg_k=4 tile
    add(1'b1, 4, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) add(1'b0, 0, 1'b1, 1'b1, rnd_beat(), rnd_beat(), 1'b1, 1'b1, 1'b0, 1'b1);
    run_vecs();
    bus.in_valid = 1'b1;
    bus.in_a = rnd_beat();
    bus.in_b = rnd_beat();
    rst = 1'b1;
    #1;
    chk("abort_h", bus.horizontal_input, '0);
    chk("abort_v", bus.vertical_input, '0);
    chk("abort_ready", W'(bus.in_ready), '0);
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_done", W'(bus.tile_done), '0);
    chk("abort_mode", W'(bus.o_mode), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb_init();
    repeat (ARR + 2) add(1'b0, 0, 1'b0, 1'b1, rnd_beat(), rnd_beat(), 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b1, rnd_beat(), rnd_beat(), 1'b1, 1'b1, 1'b0, 1'b1);
    add_tail(1'b1, ARR);
    run_vecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
